// File: rtl/sqrt_ctrl_pkg.sv
// sqrt_ctrl_pkg: shared control-word layout, ALU codes, register map and FSM states
package sqrt_ctrl_pkg;
   localparam int CTRL_W    = 14;
   localparam int ADDR_W    = 3;
   localparam int OP_W      = 2;
   localparam int SEL_BIT   = 13;
   localparam int WE_BIT    = 12;
   localparam int WADDR_LSB = 9;
   localparam int RA_LSB    = 6;
   localparam int RB_LSB    = 3;
   localparam int OP_LSB    = 1;
   localparam int OE_BIT    = 0;
   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 2'b00,
      ALU_SUB  = 2'b01,
      ALU_PASS = 2'b10,
      ALU_INC  = 2'b11
   } alu_op_e;
   localparam logic [ADDR_W-1:0] R0 = 3'd0;
   localparam logic [ADDR_W-1:0] R1 = 3'd1;
   localparam logic [ADDR_W-1:0] R2 = 3'd2;
   localparam logic [ADDR_W-1:0] R3 = 3'd3;
   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_CHECK,
      S_CLR,
      S_INIT1,
      S_INIT2,
      S_ITER,
      S_STEP1,
      S_STEP2,
      S_OUT,
      S_DONE,
      S_ERR
   } state_e;
endpackage

// File: rtl/sqrt_ctrl_word_enc.sv
// sqrt_ctrl_word_enc: packs the individual datapath control fields into the 14-bit control word
module sqrt_ctrl_word_enc
   import sqrt_ctrl_pkg::*;
(
   input  logic              sel_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic [ADDR_W-1:0] rb_i,
   input  alu_op_e           op_i,
   input  logic              oe_i,
   output logic [CTRL_W-1:0] word_o
);
   // place each field at its bit position
   always_comb begin
      word_o                         = '0;
      word_o[SEL_BIT]                = sel_i;
      word_o[WE_BIT]                 = we_i;
      word_o[WADDR_LSB +: ADDR_W]    = waddr_i;
      word_o[RA_LSB +: ADDR_W]       = ra_i;
      word_o[RB_LSB +: ADDR_W]       = rb_i;
      word_o[OP_LSB +: OP_W]         = op_i;
      word_o[OE_BIT]                 = oe_i;
   end
endmodule

// File: rtl/sqrt_sequencer.sv
// sqrt_sequencer: control FSM running integer square root by odd-number subtraction on the datapath
module sqrt_sequencer
   import sqrt_ctrl_pkg::*;
#(
   parameter int MAX_ITER = 46341,
   parameter int CNT_W    = 16
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              flg_negative_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              ready_o,
   output logic              done_o,
   output logic              err_o
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
   logic               sel, we, oe;
   logic [ADDR_W-1:0]  waddr, ra, rb;
   alu_op_e            op;

   // state and loop counter registers; reset abandons any run without a done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         iter_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         iter_cnt_q <= iter_cnt_d;
      end
   end

   // next state and control fields; all-zero defaults give the idle control word
   always_comb begin
      state_d    = state_q;
      iter_cnt_d = iter_cnt_q;
      sel        = 1'b0;
      we         = 1'b0;
      waddr      = R0;
      ra         = R0;
      rb         = R0;
      op         = ALU_ADD;
      oe         = 1'b0;
      unique case (state_q)
         S_IDLE:  state_d = start_i ? S_LOAD : S_IDLE;
         S_LOAD: begin
            sel        = 1'b1;
            we         = 1'b1;
            iter_cnt_d = '0;
            state_d    = S_CHECK;
         end
         S_CHECK: begin
            op      = ALU_PASS;
            state_d = flg_negative_i ? S_ERR : S_CLR;
         end
         S_CLR: begin
            we      = 1'b1;
            waddr   = R2;
            op      = ALU_SUB;
            state_d = S_INIT1;
         end
         S_INIT1: begin
            we      = 1'b1;
            waddr   = R1;
            ra      = R2;
            op      = ALU_INC;
            state_d = S_INIT2;
         end
         S_INIT2: begin
            we      = 1'b1;
            waddr   = R3;
            ra      = R1;
            op      = ALU_INC;
            state_d = S_ITER;
         end
         S_ITER: begin
            rb = R1;
            op = ALU_SUB;
            if (iter_cnt_q == CNT_W'(MAX_ITER)) begin
               state_d = S_ERR;
            end else begin
               we      = 1'b1;
               state_d = flg_negative_i ? S_OUT : S_STEP1;
            end
         end
         S_STEP1: begin
            we      = 1'b1;
            waddr   = R2;
            ra      = R2;
            op      = ALU_INC;
            state_d = S_STEP2;
         end
         S_STEP2: begin
            we         = 1'b1;
            waddr      = R1;
            ra         = R1;
            rb         = R3;
            iter_cnt_d = iter_cnt_q + CNT_W'(1);
            state_d    = S_ITER;
         end
         S_OUT: begin
            ra      = R2;
            op      = ALU_PASS;
            oe      = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   sqrt_ctrl_word_enc u_enc (
      .sel_i   (sel),
      .we_i    (we),
      .waddr_i (waddr),
      .ra_i    (ra),
      .rb_i    (rb),
      .op_i    (op),
      .oe_i    (oe),
      .word_o  (ctrl_o)
   );

   assign ready_o = state_q == S_IDLE;
   assign done_o  = (state_q == S_DONE) || (state_q == S_ERR);
   assign err_o   = state_q == S_ERR;
endmodule

// File: tb/tb_sqrt_sequencer.sv
// tb_sqrt_sequencer: directed bench with a behavioural register-file/ALU datapath around two sequencers
module tb_sqrt_sequencer;
   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n, start_a, start_b;
   logic [13:0] ctrl_a, ctrl_b;
   logic        ready_a, ready_b, done_a, done_b, err_a, err_b;
   logic [31:0] data_a, data_b, alu_a, alu_b, out_a, out_b;
   logic [31:0] rf_a [0:7];
   logic [31:0] rf_b [0:7];
   int          oe_a = 0, oe_b = 0;
   int          tests = 0, fails = 0;
   int          cyc, o, n_done;
   int          dc [0:2];
   logic        seen;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(input logic [13:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c[2:1])
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a;
         default: return a + 32'd1;
      endcase
   endfunction

   assign alu_a = alu(ctrl_a, rf_a[ctrl_a[8:6]], rf_a[ctrl_a[5:3]]);
   assign alu_b = alu(ctrl_b, rf_b[ctrl_b[8:6]], rf_b[ctrl_b[5:3]]);

   // datapath model A: register write and output register
   always @(posedge clk) begin
      if (ctrl_a[12]) rf_a[ctrl_a[11:9]] <= ctrl_a[13] ? data_a : alu_a;
      if (ctrl_a[0]) begin
         out_a <= alu_a;
         oe_a  <= oe_a + 1;
      end
   end

   // datapath model B: register write and output register
   always @(posedge clk) begin
      if (ctrl_b[12]) rf_b[ctrl_b[11:9]] <= ctrl_b[13] ? data_b : alu_b;
      if (ctrl_b[0]) begin
         out_b <= alu_b;
         oe_b  <= oe_b + 1;
      end
   end

   sqrt_sequencer u_a (
      .clk            (clk),
      .rst_n          (rst_a_n),
      .start_i        (start_a),
      .flg_negative_i (alu_a[31]),
      .ctrl_o         (ctrl_a),
      .ready_o        (ready_a),
      .done_o         (done_a),
      .err_o          (err_a)
   );

   sqrt_sequencer #(.MAX_ITER(4)) u_b (
      .clk            (clk),
      .rst_n          (rst_b_n),
      .start_i        (start_b),
      .flg_negative_i (alu_b[31]),
      .ctrl_o         (ctrl_b),
      .ready_o        (ready_b),
      .done_o         (done_b),
      .err_o          (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int inst, input logic [31:0] n, input int exp_cyc,
                      input logic [31:0] exp_res, input logic exp_err, input string tag);
      int c;
      @(negedge clk);
      if (inst == 0) begin data_a = n; start_a = 1'b1; end
      else begin data_b = n; start_b = 1'b1; end
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      c = 1;
      chk({tag, "_ready_low"}, inst == 0 ? ready_a : ready_b, 32'd0);
      while (!(inst == 0 ? done_a : done_b) && c < 300) begin
         @(posedge clk); #1;
         c++;
      end
      chk({tag, "_done_cycle"}, c, exp_cyc);
      chk({tag, "_err"}, inst == 0 ? err_a : err_b, exp_err);
      if (!exp_err) chk({tag, "_result"}, inst == 0 ? out_a : out_b, exp_res);
      @(posedge clk); #1;
      chk({tag, "_idle_after"}, inst == 0 ? ready_a : ready_b, 32'd1);
   endtask

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      data_a  = '0;   data_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", ctrl_a, 32'd0);
      chk("rst_ready", ready_a, 32'd1);
      chk("rst_done", done_a, 32'd0);
      chk("rst_err", err_a, 32'd0);
      @(negedge clk);
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      run(0, 32'd0, 8, 32'd0, 1'b0, "n0");
      run(0, 32'd15, 17, 32'd3, 1'b0, "n15");
      run(0, 32'd16, 20, 32'd4, 1'b0, "n16");
      o = oe_a;
      run(0, 32'h8000_0000, 3, 32'd0, 1'b1, "neg");
      chk("neg_no_oe", oe_a, o);

      o = oe_b;
      run(1, 32'd100, 19, 32'd0, 1'b1, "max4");
      chk("max4_no_oe", oe_b, o);

      // reset in cycle 10 of an N=100 run
      @(negedge clk);
      data_a = 32'd100; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 1; seen = 1'b0;
      while (cyc < 10) begin
         @(posedge clk); #1;
         cyc++;
         seen |= done_a;
      end
      rst_a_n = 1'b0;
      @(posedge clk); #1;
      seen |= done_a;
      chk("midrst_ctrl", ctrl_a, 32'd0);
      chk("midrst_ready", ready_a, 32'd1);
      chk("midrst_no_done", seen, 32'd0);
      @(negedge clk);
      rst_a_n = 1'b1;
      run(0, 32'd9, 17, 32'd3, 1'b0, "n9_after_rst");

      // start pulses while busy must be ignored
      @(negedge clk);
      data_a = 32'd16; start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      cyc = 1;
      while (!done_a && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         start_a = (cyc >= 2 && cyc <= 12) ? cyc[0] : 1'b0;
      end
      start_a = 1'b0;
      chk("busy_done_cycle", cyc, 32'd20);
      chk("busy_result", out_a, 32'd4);
      @(posedge clk); #1;
      chk("busy_idle1", ready_a, 32'd1);
      @(posedge clk); #1;
      chk("busy_not_queued", ready_a, 32'd1);

      // start held high: back-to-back runs every latency+1 cycles
      @(negedge clk);
      data_a = 32'd4; start_a = 1'b1;
      n_done = 0;
      for (int c = 1; c <= 44; c++) begin
         @(posedge clk); #1;
         if (done_a) begin
            if (n_done < 3) dc[n_done] = c;
            n_done++;
         end
      end
      start_a = 1'b0;
      chk("b2b_count", n_done, 32'd3);
      chk("b2b_done0", dc[0], 32'd14);
      chk("b2b_done1", dc[1], 32'd29);
      chk("b2b_done2", dc[2], 32'd44);
      chk("b2b_result", out_a, 32'd2);
      @(posedge clk); #1;
      chk("b2b_idle", ready_a, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
